shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult.sv | 91 +++++++++
 tb/tb_shift_add_mult.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier, one WIDTH-iteration operation in flight.
// Define ZERO_BYPASS_EN to send zero-operand requests straight to DONE with a zero product.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // Conditional add keeps the carry-out as the top bit, so the shift below never loses it.
  always_comb begin
    sum = {1'b0, acc_a};
    if (acc_q[0]) begin
      sum = {1'b0, acc_a} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc_a <= '0;
      acc_q <= '0;
      mcand <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            acc_q <= b;
            acc_a <= '0;
            count <= '0;
`ifdef ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              acc_q <= '0;
              state <= DONE;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc_a <= sum[WIDTH:1];
          acc_q <= {sum[0], acc_q[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign product   = {acc_a, acc_q};

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized self-checking bench for shift_add_mult (WIDTH=8), compared against plain a*b.
// Expected latency follows ZERO_BYPASS_EN when the same macro is defined for the bench.
module tb_shift_add_mult;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int tests_run    = 0;
  int tests_failed = 0;

  shift_add_mult #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Edges between acceptance and DONE; also the number of cycles busy should be high.
  function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef ZERO_BYPASS_EN
    if (x == 0 || y == 0) return 0;
`endif
    return WIDTH;
  endfunction

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[2*WIDTH-1:0];
  endfunction

  // Drives one operation from an IDLE negedge through its handshake; returns observations.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                               input int hold, output logic [2*WIDTH-1:0] prod,
                               output int lat, output int busy_cnt,
                               output bit stable, output bit timeout);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0;
    busy_cnt = 0;
    stable = 1'b1;
    timeout = 1'b0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      out_ready = 1'($urandom);
      a = WIDTH'($urandom);
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) timeout = 1'b1;
    prod = product;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || product !== prod || in_ready) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #2;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, product);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2*WIDTH-1:0] p;
    int lat, bc;
    bit st, to;
    applyStimulus(8'd13, 8'd11, 0, p, lat, bc, st, to);
    tests_run++;
    if (to || p !== 16'h008F || lat !== exp_lat(8'd13, 8'd11) || bc !== exp_lat(8'd13, 8'd11)) begin
      tests_failed++;
      $display("[TB] FAIL basic_13x11: product=%h lat=%0d busy=%0d timeout=%b, required 008f lat=%0d busy=%0d",
               p, lat, bc, to, exp_lat(8'd13, 8'd11), exp_lat(8'd13, 8'd11));
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h008F) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold: in_ready=%b out_valid=%b product=%h, required 1 0 008f",
               in_ready, out_valid, product);
    end
  endtask

  task automatic test_corners();
    logic [WIDTH-1:0] ca [6] = '{8'd255, 8'd255, 8'd1, 8'd0, 8'd77, 8'd0};
    logic [WIDTH-1:0] cb [6] = '{8'd255, 8'd1, 8'd255, 8'd77, 8'd0, 8'd0};
    logic [2*WIDTH-1:0] p;
    int lat, bc;
    bit st, to;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ca[i], cb[i], 0, p, lat, bc, st, to);
      tests_run++;
      if (to || p !== ref_mul(ca[i], cb[i]) || lat !== exp_lat(ca[i], cb[i]) || bc !== exp_lat(ca[i], cb[i])) begin
        tests_failed++;
        $display("[TB] FAIL corner_%0dx%0d: product=%h lat=%0d busy=%0d timeout=%b, required %h lat=%0d",
                 ca[i], cb[i], p, lat, bc, to, ref_mul(ca[i], cb[i]), exp_lat(ca[i], cb[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*WIDTH-1:0] p;
    int lat, bc;
    bit st, to;
    applyStimulus(8'd200, 8'd3, 5, p, lat, bc, st, to);
    tests_run++;
    if (to || p !== 16'h0258 || !st) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_200x3: product=%h stable=%b timeout=%b, required 0258 stable=1",
               p, st, to);
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    logic [2*WIDTH-1:0] p;
    int lat, bc, hold;
    bit st, to;
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 7 == 3) ra = '0;
      hold = int'($urandom_range(0, 3));
      applyStimulus(ra, rb, hold, p, lat, bc, st, to);
      tests_run++;
      if (to || !st || p !== ref_mul(ra, rb) || lat !== exp_lat(ra, rb)) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d %0dx%0d: product=%h lat=%0d stable=%b timeout=%b, required %h lat=%0d",
                 i, ra, rb, p, lat, st, to, ref_mul(ra, rb), exp_lat(ra, rb));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    a = 8'd13;
    b = 8'd11;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'd7;
    b = 8'd9;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (product !== 16'h008F || n !== exp_lat(8'd13, 8'd11)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: product=%h lat=%0d, required 008f lat=%0d", product, n, exp_lat(8'd13, 8'd11));
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (product !== 16'd63 || n !== exp_lat(8'd7, 8'd9)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: product=%h lat=%0d, required 003f lat=%0d", product, n, exp_lat(8'd7, 8'd9));
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    a = 8'd100;
    b = 8'd100;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_calc: out_valid=%b product=%h in_ready=%b busy=%b, required 0 0000 1 0",
               out_valid, product, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || product !== '0) seen++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_discard: stray result cycles=%0d, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
